add_flag_stage: RTL
===================

// Module: add_flag_stage
// PURPOSE
//  Registered result stage directly downstream of the N-bit carry-lookahead adder.
//  Captures operands a/b, sum s and carry-out ovf through a valid/ready handshake.
//  Derives NZCV flags and buffers results in a 2-entry skid buffer.
//  Keeps a saturating count of carry-out events for the ALU status path.
// PARAMETERS
//  N      4  datapath width; multiple of 4, matching the adder's 4-bit CLA slicing
//  CNT_W  8  width of the carry-event counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      adder result on a/b/s/ovf is valid
//  in_ready   out  1      stage can accept; registered, depends only on state
//  a          in   N      adder operand A
//  b          in   N      adder operand B
//  s          in   N      adder sum
//  ovf        in   1      adder carry-out
//  out_valid  out  1      out_sum/out_flags valid
//  out_ready  in   1      consumer accepts
//  out_sum    out  N      registered sum
//  out_flags  out  4      {N,Z,C,V}
//  cnt_clr    in   1      synchronous clear of carry counter
//  carry_cnt  out  CNT_W  saturating count of accepted results with C=1
// BEHAVIOUR
//  Reset (async, immediate): state EMPTY; in_ready=1; out_valid=0; out_sum=0; out_flags=0; carry_cnt=0.
//   Any in-flight data is dropped.
//  Transfers: accept = in_valid&in_ready; emit = out_valid&out_ready, both sampled at the clk edge.
//  Flags (combinational on the inputs, registered with the data):
//   N = s[N-1]
//   Z = (s==0)
//   C = ovf
//   V = (a[N-1]==b[N-1]) & (s[N-1]!=a[N-1])
//  Latency: 1 cycle from accept to out_valid when the stage is EMPTY.
//  Storage: main reg drives the outputs; skid reg holds one extra entry.
//  FSM:
//   EMPTY: accept -> ONE (main<=in).
//   ONE: accept&!emit -> TWO (skid<=in).
//    emit&!accept -> EMPTY.
//    accept&emit -> ONE (main<=in).
//   TWO: in_ready=0; emit -> ONE (main<=skid).
//  Ordering: strict FIFO; no result is dropped or duplicated.
//  in_ready:
//   1 in EMPTY and ONE, 0 in TWO.
//   Never combinationally depends on out_ready.
//  out_valid: 1 in ONE and TWO. out_sum/out_flags stay stable while out_valid&!out_ready.
//  Counter:
//   Increments on accept with ovf=1.
//   Saturates at 2^CNT_W-1 with no wrap.
//   If cnt_clr and accept coincide, cnt_clr wins: result is 0 and the event is not counted.
//  Corner cases:
//   N=4 with s=0 and ovf=1 (e.g. a=8,b=8) -> Z=1, C=1, V=1.
//   out_ready held high with continuous in_valid -> 1 result/cycle; state never leaves ONE.
// STRUCTURE
//  alu_pkg:
//   typedef struct packed {logic n,z,c,v;} flags_t
//   typedef enum logic [1:0] {EMPTY,ONE,TWO} skid_state_t
//   FLAG_N/Z/C/V bit-index constants
//  Sub-module add_flag_gen: combinational (a,b,s,ovf) -> flags_t, reused by other ALU ops.
//  Top level holds the FSM, main/skid registers and the counter.
// TESTING
//  Reset mid-TWO (two entries held, out_ready=0) -> next cycle out_valid=0, in_ready=1, carry_cnt=0.
//  N=4, a=3,b=4,s=7,ovf=0 into EMPTY -> next cycle out_sum=7, flags N0 Z0 C0 V0; then a=7,b=1,s=8 -> N1 Z0 C0 V1.
//  out_ready=0, three back-to-back results R1,R2,R3 -> R1,R2 accepted, in_ready=0 at R3;
//   then out_ready=1 -> outputs R1,R2,R3 in order with no loss.
//  Streaming 16 results with out_ready=1 -> 16 outputs on consecutive cycles, each 1 cycle after accept.
//  CNT_W=2, five carry events -> carry_cnt 1,2,3,3,3; cnt_clr with a carry accept -> 0.
//  a=8,b=8,s=0,ovf=1 -> flags N0 Z1 C1 V1.

Source files
------------

// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg : shared ALU status types (NZCV flags, skid-buffer states)   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // Bit positions of each flag within a packed {N,Z,C,V} vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/add_flag_gen.sv
// +----------------------------------------------------------------------+
// | add_flag_gen : combinational NZCV derivation for an addition result  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module add_flag_gen
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] s,
  input  logic         ovf,
  output flags_t       flags
);

  // Only operand sign bits matter for signed overflow
  logic w_unused_bits;
  assign w_unused_bits = ^{a[N-2:0], b[N-2:0]};

  always_comb begin
    flags   = '0;
    flags.n = s[N-1];
    flags.z = (s == '0);
    flags.c = ovf;
    flags.v = (a[N-1] == b[N-1]) & (s[N-1] != a[N-1]);
  end

endmodule

`default_nettype wire

// File: rtl/add_flag_stage.sv
// +----------------------------------------------------------------------+
// | add_flag_stage : registered adder result stage with NZCV flags,      |
// | 2-entry skid buffer and saturating carry-event counter               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module add_flag_stage
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     s,
  input  logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic [3:0]       out_flags,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  skid_state_t      r_state;
  logic [N-1:0]     r_main_sum;
  logic [N-1:0]     r_skid_sum;
  flags_t           r_main_flags;
  flags_t           r_skid_flags;
  logic [CNT_W-1:0] r_cnt;
  flags_t           w_flags;
  logic             w_accept;
  logic             w_emit;

  add_flag_gen #(.N(N)) u_flag_gen (
    .a     (a),
    .b     (b),
    .s     (s),
    .ovf   (ovf),
    .flags (w_flags)
  );

  // Handshake readiness decodes purely from the state register
  assign in_ready  = (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign out_sum   = r_main_sum;
  assign out_flags = r_main_flags;
  assign carry_cnt = r_cnt;

  assign w_accept = in_valid & in_ready;
  assign w_emit   = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_main_sum   <= '0;
      r_main_flags <= '0;
      r_skid_sum   <= '0;
      r_skid_flags <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main_sum   <= s;
            r_main_flags <= w_flags;
            r_state      <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_emit) begin
            r_main_sum   <= s;
            r_main_flags <= w_flags;
          end else if (w_accept) begin
            r_skid_sum   <= s;
            r_skid_flags <= w_flags;
            r_state      <= TWO;
          end else if (w_emit) begin
            r_state      <= EMPTY;
          end
        end
        TWO: begin
          if (w_emit) begin
            r_main_sum   <= r_skid_sum;
            r_main_flags <= r_skid_flags;
            r_state      <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Clear takes priority over a coincident carry event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_accept && ovf && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
